// File: rtl/mbist_fail_logger.sv
// Memory BIST fail logger: registers failing compares while armed and queues
// {addr, op, data} records in a small FIFO, alongside a saturating count, first-fail address and overflow flag.
module mbist_fail_logger #(
  parameter int unsigned AW    = 8,
  parameter int unsigned DW    = 8,
  parameter int unsigned CW    = 4,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNTW  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                test_done,
  input  logic                cmp_en,
  input  logic [AW-1:0]       tas_in,
  input  logic [CW-1:0]       tcs_in,
  input  logic [DW-1:0]       tds_in,
  input  logic                passfail_in,
  input  logic                rd_ready,
  output logic                rd_valid,
  output logic [AW+CW+DW-1:0] rd_data,
  output logic [CNTW-1:0]     fail_count,
  output logic [AW-1:0]       first_fail_addr,
  output logic                overflow,
  output logic                busy,
  output logic                done,
  output logic                pass
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned RW = AW + CW + DW;

  typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;

  state_t            state, state_nxt;
  logic              cap_v;
  logic [RW-1:0]     cap_rec;
  logic [RW-1:0]     mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [PW:0]       count, count_nxt;
  logic              push, pop, full, empty;
  logic [CNTW-1:0]   fail_count_nxt;
  logic [AW-1:0]     first_fail_nxt;
  logic              overflow_nxt;
  logic [RW-1:0]     rd_data_nxt;

  // Control state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state: start always (re)arms and beats test_done
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ARMED;
      ARMED:   if (start) state_nxt = ARMED;
               else if (test_done) state_nxt = DONE;
      DONE:    if (start) state_nxt = ARMED;
      default: state_nxt = IDLE;
    endcase
  end

  // One-stage capture; it drains regardless of state so a fail on the test_done cycle still lands
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_v   <= 1'b0;
      cap_rec <= '0;
    end else begin
      cap_v   <= (state == ARMED) && cmp_en && passfail_in;
      cap_rec <= {tas_in, tcs_in, tds_in};
    end
  end

  assign empty = (count == '0);
  assign full  = (count == (PW+1)'(DEPTH));
  assign pop   = !empty && rd_ready && !start;
  assign push  = cap_v && (!full || pop) && !start;

  // Log/FIFO next-state; start overrides everything with a clear
  always_comb begin
    wr_ptr_nxt     = wr_ptr;
    rd_ptr_nxt     = rd_ptr;
    count_nxt      = count;
    fail_count_nxt = fail_count;
    first_fail_nxt = first_fail_addr;
    overflow_nxt   = overflow;
    rd_data_nxt    = '0;
    if (start) begin
      wr_ptr_nxt     = '0;
      rd_ptr_nxt     = '0;
      count_nxt      = '0;
      fail_count_nxt = '0;
      first_fail_nxt = '0;
      overflow_nxt   = 1'b0;
    end else begin
      if (push) wr_ptr_nxt = wr_ptr + PW'(1);
      if (pop)  rd_ptr_nxt = rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count_nxt = count + (PW+1)'(1);
        2'b01:   count_nxt = count - (PW+1)'(1);
        default: count_nxt = count;
      endcase
      if (cap_v) begin
        if (fail_count != '1) fail_count_nxt = fail_count + CNTW'(1);
        if (fail_count == '0) first_fail_nxt = cap_rec[RW-1 -: AW];
        if (full && !pop)     overflow_nxt   = 1'b1;
      end
      // Head slot may be the one being written this cycle
      if (count_nxt != '0) begin
        if (push && (wr_ptr == rd_ptr_nxt)) rd_data_nxt = cap_rec;
        else                                rd_data_nxt = mem[rd_ptr_nxt];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      fail_count      <= '0;
      first_fail_addr <= '0;
      overflow        <= 1'b0;
      rd_valid        <= 1'b0;
      rd_data         <= '0;
    end else begin
      wr_ptr          <= wr_ptr_nxt;
      rd_ptr          <= rd_ptr_nxt;
      count           <= count_nxt;
      fail_count      <= fail_count_nxt;
      first_fail_addr <= first_fail_nxt;
      overflow        <= overflow_nxt;
      rd_valid        <= (count_nxt != '0);
      rd_data         <= rd_data_nxt;
    end
  end

  // Record storage; contents are only visible through the pointers, so no reset needed
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cap_rec;
  end

  assign busy = (state == ARMED);
  assign done = (state == DONE);
  assign pass = done && (fail_count == '0);

endmodule

// File: tb/tb_mbist_fail_logger.sv
// Directed bench for mbist_fail_logger: each task drives one scenario and checks against hand-computed values.
module tb_mbist_fail_logger;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, test_done, cmp_en, passfail_in, rd_ready;
  logic [7:0]  tas_in, tds_in;
  logic [3:0]  tcs_in;
  logic        rd_valid, overflow, busy, done, pass;
  logic [19:0] rd_data;
  logic [15:0] fail_count;
  logic [7:0]  first_fail_addr;

  int tests = 0;
  int fails = 0;

  mbist_fail_logger dut (
    .clk(clk), .rst(rst), .start(start), .test_done(test_done), .cmp_en(cmp_en),
    .tas_in(tas_in), .tcs_in(tcs_in), .tds_in(tds_in), .passfail_in(passfail_in),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .fail_count(fail_count),
    .first_fail_addr(first_fail_addr), .overflow(overflow), .busy(busy), .done(done), .pass(pass)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_done();
    test_done = 1'b1; tick(); test_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 0; test_done = 0; cmp_en = 0; passfail_in = 0; rd_ready = 0;
    tas_in = 0; tcs_in = 0; tds_in = 0;
    #2;
    tests++; if ({rd_valid, overflow, busy, done, pass} !== 5'b0) begin fails++;
      $display("FAIL reset_flags: got %b want 00000", {rd_valid, overflow, busy, done, pass}); end
    tests++; if (rd_data !== 20'h0 || fail_count !== 16'h0 || first_fail_addr !== 8'h0) begin fails++;
      $display("FAIL reset_values: data %h count %0d first %h want 0", rd_data, fail_count, first_fail_addr); end
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_clean();
    pulse_start();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL clean_busy: got %b want 1", busy); end
    for (int i = 0; i < 20; i++) begin
      cmp_en = 1; passfail_in = 0; tas_in = 8'(i); tick();
    end
    cmp_en = 0;
    pulse_done();
    tick();
    tests++; if ({busy, done, pass} !== 3'b011) begin fails++;
      $display("FAIL clean_status: busy/done/pass got %b want 011", {busy, done, pass}); end
    tests++; if (fail_count !== 16'd0 || rd_valid !== 1'b0) begin fails++;
      $display("FAIL clean_log: count %0d valid %b want 0 0", fail_count, rd_valid); end
  endtask

  task automatic test_single_fail();
    pulse_start();
    cmp_en = 1; passfail_in = 1; tas_in = 8'h2A; tcs_in = 4'h3; tds_in = 8'h55;
    tick();
    cmp_en = 0; passfail_in = 0; tas_in = 0; tcs_in = 0; tds_in = 0;
    tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL single_n1_valid: got %b want 0", rd_valid); end
    tick();
    tests++; if (rd_valid !== 1'b1) begin fails++; $display("FAIL single_n2_valid: got %b want 1", rd_valid); end
    tests++; if (rd_data !== 20'h2A355) begin fails++; $display("FAIL single_data: got %h want 2a355", rd_data); end
    tests++; if (first_fail_addr !== 8'h2A || fail_count !== 16'd1) begin fails++;
      $display("FAIL single_stats: first %h count %0d want 2a 1", first_fail_addr, fail_count); end
    pulse_done();
    tests++; if (done !== 1'b1 || pass !== 1'b0) begin fails++;
      $display("FAIL single_pass: done %b pass %b want 1 0", done, pass); end
    tests++; if (rd_valid !== 1'b1 || rd_data !== 20'h2A355) begin fails++;
      $display("FAIL single_hold: valid %b data %h want 1 2a355", rd_valid, rd_data); end
    rd_ready = 1; tick(); rd_ready = 0;
    tests++; if (rd_valid !== 1'b0 || rd_data !== 20'h0) begin fails++;
      $display("FAIL single_drained: valid %b data %h want 0 0", rd_valid, rd_data); end
  endtask

  task automatic test_masked();
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      cmp_en = 0; passfail_in = 1; tas_in = 8'(i); tick();
    end
    passfail_in = 0; tick(); tick();
    tests++; if (fail_count !== 16'd0 || rd_valid !== 1'b0) begin fails++;
      $display("FAIL masked: count %0d valid %b want 0 0", fail_count, rd_valid); end
  endtask

  task automatic test_overflow();
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      cmp_en = 1; passfail_in = 1; tas_in = 8'(i); tcs_in = 4'h1; tds_in = 8'(i + 8'hA0); tick();
    end
    cmp_en = 0; passfail_in = 0; tick(); tick();
    tests++; if (fail_count !== 16'd10 || overflow !== 1'b1) begin fails++;
      $display("FAIL ovf_stats: count %0d ovf %b want 10 1", fail_count, overflow); end
    tests++; if (first_fail_addr !== 8'h00) begin fails++; $display("FAIL ovf_first: got %h want 00", first_fail_addr); end
    for (int i = 0; i < 8; i++) begin
      tests++; if (rd_valid !== 1'b1 || rd_data !== {8'(i), 4'h1, 8'(i + 8'hA0)}) begin fails++;
        $display("FAIL ovf_read%0d: valid %b data %h want 1 %h", i, rd_valid, rd_data, {8'(i), 4'h1, 8'(i + 8'hA0)}); end
      rd_ready = 1; tick();
    end
    rd_ready = 0;
    tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL ovf_empty: got %b want 0", rd_valid); end
  endtask

  task automatic test_full_pop();
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      cmp_en = 1; passfail_in = 1; tas_in = 8'(i); tcs_in = 4'h2; tds_in = 8'h0F; tick();
    end
    cmp_en = 0; passfail_in = 0; tick();
    cmp_en = 1; passfail_in = 1; tas_in = 8'd8; tick();
    cmp_en = 0; passfail_in = 0;
    rd_ready = 1; tick(); rd_ready = 0;
    tests++; if (overflow !== 1'b0 || fail_count !== 16'd9) begin fails++;
      $display("FAIL fullpop_stats: ovf %b count %0d want 0 9", overflow, fail_count); end
    tests++; if (rd_data[19:12] !== 8'd1) begin fails++; $display("FAIL fullpop_head: got %h want 01", rd_data[19:12]); end
    for (int i = 1; i <= 8; i++) begin
      tests++; if (rd_valid !== 1'b1 || rd_data[19:12] !== 8'(i)) begin fails++;
        $display("FAIL fullpop_read%0d: valid %b addr %h want 1 %h", i, rd_valid, rd_data[19:12], 8'(i)); end
      rd_ready = 1; tick();
    end
    rd_ready = 0;
    tests++; if (rd_valid !== 1'b0 || overflow !== 1'b0) begin fails++;
      $display("FAIL fullpop_empty: valid %b ovf %b want 0 0", rd_valid, overflow); end
  endtask

  task automatic test_done_drain();
    pulse_start();
    cmp_en = 1; passfail_in = 1; tas_in = 8'h77; tcs_in = 4'h5; tds_in = 8'h12; test_done = 1;
    start = 1;
    tick();
    start = 0;
    tests++; if (busy !== 1'b1 || done !== 1'b0) begin fails++;
      $display("FAIL start_wins: busy %b done %b want 1 0", busy, done); end
    tick();
    test_done = 0; cmp_en = 0; passfail_in = 0;
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL drain_done: got %b want 1", done); end
    tick();
    tests++; if (fail_count !== 16'd2 || rd_data !== 20'h77512) begin fails++;
      $display("FAIL drain_logged: count %0d data %h want 2 77512", fail_count, rd_data); end
    cmp_en = 1; passfail_in = 1; tick(); tick(); tick();
    cmp_en = 0; passfail_in = 0;
    tests++; if (fail_count !== 16'd2) begin fails++; $display("FAIL done_ignored: got %0d want 2", fail_count); end
  endtask

  task automatic test_rearm_reset();
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      cmp_en = 1; passfail_in = 1; tas_in = 8'(8'h30 + i); tick();
    end
    cmp_en = 0; passfail_in = 0; tick(); tick();
    tests++; if (fail_count !== 16'd3 || first_fail_addr !== 8'h30) begin fails++;
      $display("FAIL rearm_pre: count %0d first %h want 3 30", fail_count, first_fail_addr); end
    pulse_start();
    tests++; if (fail_count !== 16'd0 || rd_valid !== 1'b0 || overflow !== 1'b0 || first_fail_addr !== 8'h0 || busy !== 1'b1) begin
      fails++; $display("FAIL rearm_clear: count %0d valid %b ovf %b first %h busy %b want 0 0 0 00 1",
        fail_count, rd_valid, overflow, first_fail_addr, busy); end
    cmp_en = 1; passfail_in = 1; tas_in = 8'h44; tick(); tick();
    cmp_en = 0; passfail_in = 0;
    #3 rst = 1'b0;
    #1;
    tests++; if ({rd_valid, overflow, busy, done, pass} !== 5'b0 || fail_count !== 16'd0 || rd_data !== 20'h0 || first_fail_addr !== 8'h0) begin
      fails++; $display("FAIL midtest_reset: flags %b count %0d data %h first %h want 0",
        {rd_valid, overflow, busy, done, pass}, fail_count, rd_data, first_fail_addr); end
    tick();
    rst = 1'b1;
    pulse_done();
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++;
      $display("FAIL idle_ignores_done: busy %b done %b want 0 0", busy, done); end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single_fail();
    test_masked();
    test_overflow();
    test_full_pop();
    test_done_drain();
    test_rearm_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
